// File: rtl/add_arbiter.sv
// add_arbiter: two-requester round-robin front end for one shared 32-bit
// adder. Stage S1 holds the granted operands and drives the external adder;
// stage S2 captures the adder result and presents it as the response.
module add_arbiter (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req0_valid,
  output logic        o_req0_ready,
  input  logic [31:0] i_req0_a,
  input  logic [31:0] i_req0_b,
  input  logic        i_req0_sub,
  input  logic        i_req1_valid,
  output logic        o_req1_ready,
  input  logic [31:0] i_req1_a,
  input  logic [31:0] i_req1_b,
  input  logic        i_req1_sub,
  output logic [31:0] o_add_a,
  output logic [31:0] o_add_b,
  output logic        o_add_cin,
  input  logic [31:0] i_add_sum,
  input  logic        i_add_cout,
  output logic        o_rsp_valid,
  output logic        o_rsp_id,
  output logic [31:0] o_rsp_sum,
  output logic        o_rsp_cout,
  input  logic        i_rsp_ready,
  output logic [15:0] o_cnt0,
  output logic [15:0] o_cnt1
);

  // Saturating 16-bit increment used by both acceptance counters.
  function automatic logic [15:0] sat_inc(input logic [15:0] val);
    logic [15:0] res;
    if (val == 16'hFFFF) begin
      res = val;
    end else begin
      res = val + 16'd1;
    end
    return res;
  endfunction

  // S1 operand stage
  logic        r_s1_valid;
  logic        r_s1_id;
  logic [31:0] r_s1_a;
  logic [31:0] r_s1_b;
  logic        r_s1_sub;
  // S2 result stage
  logic        r_s2_valid;
  logic        r_s2_id;
  logic [31:0] r_s2_sum;
  logic        r_s2_cout;
  // Round-robin pointer: requester favoured when both are valid
  logic        r_ptr;
  logic [15:0] r_cnt0;
  logic [15:0] r_cnt1;

  logic        w_s2_hold;
  logic        w_s1_free;
  logic        w_sel_valid;
  logic        w_sel_id;
  logic        w_req0_ready;
  logic        w_req1_ready;
  logic        w_accept;
  logic [31:0] w_sel_a;
  logic [31:0] w_sel_b;
  logic        w_sel_sub;

  // S2 stalls only when it holds a response the consumer is not taking;
  // S1 can take a new op if it is empty or is moving into S2 this cycle.
  assign w_s2_hold = r_s2_valid & ~i_rsp_ready;
  assign w_s1_free = ~r_s1_valid | ~w_s2_hold;

  // Grant selection: a lone requester always wins, contention uses the pointer.
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_id    = 1'b0;
    if (i_req0_valid && i_req1_valid) begin
      w_sel_valid = 1'b1;
      w_sel_id    = r_ptr;
    end else if (i_req0_valid) begin
      w_sel_valid = 1'b1;
      w_sel_id    = 1'b0;
    end else if (i_req1_valid) begin
      w_sel_valid = 1'b1;
      w_sel_id    = 1'b1;
    end else begin
      w_sel_valid = 1'b0;
      w_sel_id    = 1'b0;
    end
  end

  // Operand mux for the granted requester.
  always_comb begin
    w_sel_a   = 32'd0;
    w_sel_b   = 32'd0;
    w_sel_sub = 1'b0;
    if (w_sel_id) begin
      w_sel_a   = i_req1_a;
      w_sel_b   = i_req1_b;
      w_sel_sub = i_req1_sub;
    end else begin
      w_sel_a   = i_req0_a;
      w_sel_b   = i_req0_b;
      w_sel_sub = i_req0_sub;
    end
  end

  assign w_req0_ready = w_sel_valid & ~w_sel_id & w_s1_free;
  assign w_req1_ready = w_sel_valid &  w_sel_id & w_s1_free;
  assign w_accept     = w_req0_ready | w_req1_ready;

  assign o_req0_ready = w_req0_ready;
  assign o_req1_ready = w_req1_ready;

  // S1 register: load the granted op when free, otherwise hold.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_s1_valid <= 1'b0;
      r_s1_id    <= 1'b0;
      r_s1_a     <= 32'd0;
      r_s1_b     <= 32'd0;
      r_s1_sub   <= 1'b0;
    end else if (w_s1_free) begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_id  <= w_sel_id;
        r_s1_a   <= w_sel_a;
        r_s1_b   <= w_sel_b;
        r_s1_sub <= w_sel_sub;
      end else begin
        r_s1_id  <= r_s1_id;
        r_s1_a   <= r_s1_a;
        r_s1_b   <= r_s1_b;
        r_s1_sub <= r_s1_sub;
      end
    end else begin
      r_s1_valid <= r_s1_valid;
      r_s1_id    <= r_s1_id;
      r_s1_a     <= r_s1_a;
      r_s1_b     <= r_s1_b;
      r_s1_sub   <= r_s1_sub;
    end
  end

  // S2 register: capture the adder result from S1 unless stalled by the consumer.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_s2_valid <= 1'b0;
      r_s2_id    <= 1'b0;
      r_s2_sum   <= 32'd0;
      r_s2_cout  <= 1'b0;
    end else if (!w_s2_hold) begin
      r_s2_valid <= r_s1_valid;
      r_s2_id    <= r_s1_id;
      r_s2_sum   <= i_add_sum;
      r_s2_cout  <= i_add_cout;
    end else begin
      r_s2_valid <= r_s2_valid;
      r_s2_id    <= r_s2_id;
      r_s2_sum   <= r_s2_sum;
      r_s2_cout  <= r_s2_cout;
    end
  end

  // Pointer moves to the other requester only when an op is actually accepted.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ptr <= 1'b0;
    end else if (w_accept) begin
      r_ptr <= ~w_sel_id;
    end else begin
      r_ptr <= r_ptr;
    end
  end

  // Per-requester saturating acceptance counters.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt0 <= 16'd0;
      r_cnt1 <= 16'd0;
    end else begin
      r_cnt0 <= (i_req0_valid & w_req0_ready) ? sat_inc(r_cnt0) : r_cnt0;
      r_cnt1 <= (i_req1_valid & w_req1_ready) ? sat_inc(r_cnt1) : r_cnt1;
    end
  end

  assign o_add_a     = r_s1_a;
  assign o_add_b     = r_s1_b;
  assign o_add_cin   = r_s1_sub;
  assign o_rsp_valid = r_s2_valid;
  assign o_rsp_id    = r_s2_id;
  assign o_rsp_sum   = r_s2_sum;
  assign o_rsp_cout  = r_s2_cout;
  assign o_cnt0      = r_cnt0;
  assign o_cnt1      = r_cnt1;

endmodule

// File: tb/tb_add_arbiter.sv
// Testbench for add_arbiter: models the external adder, tracks accepted ops
// in a scoreboard queue and compares each response as it is consumed.
module tb_add_arbiter;

  logic        clk;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        req0_sub, req1_sub;
  logic [31:0] add_a, add_b, add_sum;
  logic        add_cin, add_cout;
  logic        rsp_valid, rsp_id, rsp_cout, rsp_ready;
  logic [31:0] rsp_sum;
  logic [15:0] cnt0, cnt1;

  int checks   = 0;
  int failures = 0;
  int n_rsp    = 0;
  logic [33:0] sb_q[$];   // {id, cout, sum}
  bit          acc_q[$];  // accepted requester ids in order
  logic [31:0] held_sum;

  add_arbiter dut (
    .i_clk(clk), .i_reset(reset),
    .i_req0_valid(req0_valid), .o_req0_ready(req0_ready),
    .i_req0_a(req0_a), .i_req0_b(req0_b), .i_req0_sub(req0_sub),
    .i_req1_valid(req1_valid), .o_req1_ready(req1_ready),
    .i_req1_a(req1_a), .i_req1_b(req1_b), .i_req1_sub(req1_sub),
    .o_add_a(add_a), .o_add_b(add_b), .o_add_cin(add_cin),
    .i_add_sum(add_sum), .i_add_cout(add_cout),
    .o_rsp_valid(rsp_valid), .o_rsp_id(rsp_id), .o_rsp_sum(rsp_sum),
    .o_rsp_cout(rsp_cout), .i_rsp_ready(rsp_ready),
    .o_cnt0(cnt0), .o_cnt1(cnt1)
  );

  // Shared combinational adder: b inverted internally when cin=1.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, (add_cin ? ~add_b : add_b)} + {32'd0, add_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference result: plain add, or subtract with cout=1 meaning no borrow.
  function automatic logic [32:0] ref_op(input logic [31:0] a, input logic [31:0] b, input logic sub);
    logic [32:0] r;
    if (sub) begin
      r = {(a >= b) ? 1'b1 : 1'b0, a - b};
    end else begin
      r = {1'b0, a} + {1'b0, b};
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clock: scoreboard work at negedge, then return just after posedge.
  task automatic cycle();
    logic [33:0] e;
    @(negedge clk);
    if (reset) begin
      sb_q.delete();
    end else begin
      check("one_ready", 64'(req0_ready & req1_ready), 64'd0);
      check("ready_wo_valid", 64'((req0_ready & ~req0_valid) | (req1_ready & ~req1_valid)), 64'd0);
      if (rsp_valid && rsp_ready) begin
        check("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check("rsp_data", 64'({rsp_id, rsp_cout, rsp_sum}), 64'(e));
          n_rsp++;
        end
      end
      if (req0_valid && req0_ready) begin
        sb_q.push_back({1'b0, ref_op(req0_a, req0_b, req0_sub)});
        acc_q.push_back(1'b0);
      end
      if (req1_valid && req1_ready) begin
        sb_q.push_back({1'b1, ref_op(req1_a, req1_b, req1_sub)});
        acc_q.push_back(1'b1);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    cycle();
    cycle();
    reset = 1'b0;
    acc_q.delete();
    n_rsp = 0;
  endtask

  task automatic drain();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (sb_q.size() != 0 || rsp_valid) cycle();
    end
    check("drain_empty", 64'(sb_q.size()), 64'd0);
  endtask

  task automatic rand_ops();
    req0_a = $urandom; req0_b = $urandom; req0_sub = 1'($urandom_range(1));
    req1_a = $urandom; req1_b = $urandom; req1_sub = 1'($urandom_range(1));
  endtask

  initial begin
    reset = 1'b1; rsp_ready = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = 32'd0; req0_b = 32'd0; req0_sub = 1'b0;
    req1_a = 32'd0; req1_b = 32'd0; req1_sub = 1'b0;
    do_reset();

    // Reset state
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_cnt0", 64'(cnt0), 64'd0);
    check("rst_cnt1", 64'(cnt1), 64'd0);
    check("rst_add_a", 64'(add_a), 64'd0);
    check("rst_add_cin", 64'(add_cin), 64'd0);
    check("rst_ready0", 64'(req0_ready), 64'd0);

    // Single add on requester 0, two-edge latency
    req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd3; req0_sub = 1'b0;
    #1 check("r31_ready0", 64'(req0_ready), 64'd1);
    cycle();
    req0_valid = 1'b0;
    check("r31_lat_early", 64'(rsp_valid), 64'd0);
    cycle();
    check("r31_valid", 64'(rsp_valid), 64'd1);
    check("r31_sum", 64'(rsp_sum), 64'd8);
    check("r31_cout", 64'(rsp_cout), 64'd0);
    check("r31_id", 64'(rsp_id), 64'd0);
    check("r31_cnt0", 64'(cnt0), 64'd1);
    cycle();

    // Requester 1: subtract with borrow, then add with carry-out
    req1_valid = 1'b1; req1_a = 32'd3; req1_b = 32'd5; req1_sub = 1'b1;
    cycle();
    req1_a = 32'hFFFF_FFFF; req1_b = 32'd1; req1_sub = 1'b0;
    cycle();
    req1_valid = 1'b0;
    check("r32_sub_sum", 64'(rsp_sum), 64'h0000_0000_FFFF_FFFE);
    check("r32_sub_cout", 64'(rsp_cout), 64'd0);
    check("r32_sub_id", 64'(rsp_id), 64'd1);
    cycle();
    check("r32_add_sum", 64'(rsp_sum), 64'd0);
    check("r32_add_cout", 64'(rsp_cout), 64'd1);
    drain();

    // Continuous contention alternates grants starting at requester 0
    do_reset();
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      rand_ops();
      cycle();
    end
    drain();
    check("r33_nacc", 64'(acc_q.size()), 64'd6);
    for (int i = 0; i < 6 && i < acc_q.size(); i++) begin
      check("r33_grant_order", 64'(acc_q[i]), 64'(i % 2));
    end
    check("r33_cnt0", 64'(cnt0), 64'd3);
    check("r33_cnt1", 64'(cnt1), 64'd3);
    check("r33_nrsp", 64'(n_rsp), 64'd6);

    // Full backpressure: two ops fill S1/S2, then both readies drop
    do_reset();
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rand_ops();
      cycle();
    end
    check("r34_nacc", 64'(acc_q.size()), 64'd2);
    check("r34_ready_low", 64'({req0_ready, req1_ready}), 64'd0);
    held_sum = rsp_sum;
    cycle();
    cycle();
    check("r34_held_valid", 64'(rsp_valid), 64'd1);
    check("r34_held_sum", 64'(rsp_sum), 64'(held_sum));
    drain();
    check("r34_nrsp", 64'(n_rsp), 64'd2);

    // Reset with S1 and S2 occupied discards both ops
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    rand_ops();
    cycle();
    cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    acc_q.delete();
    check("r35_rsp_valid", 64'(rsp_valid), 64'd0);
    check("r35_cnt0", 64'(cnt0), 64'd0);
    check("r35_cnt1", 64'(cnt1), 64'd0);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1 check("r35_grant", 64'({req0_ready, req1_ready}), 64'b10);
    cycle();
    drain();
    check("r35_first_id", 64'(acc_q.size() > 0 ? acc_q[0] : 1'b1), 64'd0);

    // Counter saturation on requester 0
    do_reset();
    req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd2; req0_sub = 1'b0;
    for (int i = 0; i < 65534; i++) cycle();
    check("r36_cnt0_fffe", 64'(cnt0), 64'h0000_0000_0000_FFFE);
    for (int i = 0; i < 6; i++) cycle();
    check("r36_cnt0_sat", 64'(cnt0), 64'h0000_0000_0000_FFFF);
    check("r36_cnt1", 64'(cnt1), 64'd0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
